instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 The block SHALL have parameter INST_SZ, default 32, meaning instruction word width in bits (a multiple of BYTE_SZ).
REQ-002 The block SHALL have parameter BYTE_SZ, default 8, meaning width of each incoming byte.
REQ-003 The block SHALL have parameter ADDR_SZ, default 8, meaning instruction memory word-address width (depth 2^ADDR_SZ words).
REQ-004 Port: i_clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port: i_reset  input  1  asynchronous, active-low reset.
REQ-006 Port: i_rx_data  input  BYTE_SZ  received byte from the serial receiver.
REQ-007 Port: i_rx_valid  input  1  one-cycle strobe marking i_rx_data valid.
REQ-008 Port: i_clear  input  1  synchronous restart of a new load session.
REQ-009 Port: o_ready  output  1  high when a byte will be accepted this cycle.
REQ-010 Port: o_write  output  1  one-cycle instruction memory write strobe; drives the pipeline's i_write.
REQ-011 Port: o_instruction  output  INST_SZ  assembled word; drives the pipeline's i_instruction.
REQ-012 Port: o_addr  output  ADDR_SZ  word address for the current write.
REQ-013 Port: o_word_count  output  ADDR_SZ+1  number of words written this session.
REQ-014 Port: o_done  output  1  load finished successfully; pipeline may be released.
REQ-015 Port: o_error  output  1  load aborted (overflow or checksum mismatch).

Function
REQ-016 The FSM SHALL have states RECV, WRITE, CHECK (only with the macro), DONE and ERROR.
REQ-017 o_ready SHALL be high only in RECV; a byte with i_rx_valid high while o_ready is low SHALL be dropped with no state change.
REQ-018 In RECV each accepted byte SHALL shift into the word buffer; the first byte of a word is the MSB (big-endian).
REQ-019 On the INST_SZ/BYTE_SZ-th accepted byte the FSM SHALL go to WRITE; o_write SHALL be high for exactly that one WRITE cycle, with o_instruction equal to the full word and o_addr equal to the current address.
REQ-020 Latency SHALL be one cycle from the clock edge accepting the last byte to o_write high.
REQ-021 After WRITE, o_addr and o_word_count SHALL each increment by 1 and the byte counter SHALL clear.
REQ-022 A written word equal to all ones (HALT, 32'hFFFFFFFF) SHALL be written like any other word and SHALL end the session: next state DONE, or CHECK with the macro.
REQ-023 If a non-HALT word is written at address 2^ADDR_SZ-1, the FSM SHALL go to ERROR (overflow); o_addr SHALL NOT wrap.
REQ-024 o_done SHALL be high only in DONE and o_error only in ERROR; both states SHALL hold until i_clear or reset.
REQ-025 i_clear SHALL return the FSM to RECV from any state with address, byte counter and word count zeroed; it takes priority over a simultaneous i_rx_valid, which is dropped.
REQ-026 o_instruction SHALL hold its last value outside WRITE.

Reset
REQ-027 Assertion of i_reset low SHALL immediately force state RECV, o_write 0, o_instruction 0, o_addr 0, o_word_count 0, o_done 0, o_error 0, byte counter 0, checksum 0.
REQ-028 Reset mid-word SHALL discard all partial bytes; o_ready SHALL be high in the first cycle after reset deassertion.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN SHALL control the trailing checksum feature.
REQ-030 With LOADER_CHECKSUM_EN defined: a running XOR of every accepted word byte SHALL be kept; after HALT the FSM SHALL enter CHECK, accept one byte, and go to DONE if it equals the XOR, or to ERROR otherwise.
REQ-031 Without LOADER_CHECKSUM_EN: no checksum register or CHECK state SHALL exist, and HALT SHALL go directly to DONE.

Verification
REQ-032 Bytes 20,08,00,05 then FF,FF,FF,FF -> o_write at addr 0 with 32'h20080005, then at addr 1 with 32'hFFFFFFFF; o_word_count 2; o_done 1.
REQ-033 i_rx_valid pulsed during WRITE and DONE -> bytes dropped, no extra o_write, o_word_count unchanged.
REQ-034 ADDR_SZ=2, four non-HALT words -> fourth written at addr 3, then o_error 1 and o_addr stays 3.
REQ-035 Reset pulsed low after 2 bytes, then 4 bytes AA,BB,CC,DD -> single write of 32'hAABBCCDD at addr 0.
REQ-036 Macro defined, word 01020304, HALT, checksum 04 -> o_done; repeat with checksum 05 -> o_error.
REQ-037 i_clear asserted in DONE together with i_rx_valid -> RECV with count 0; that byte not included in the next word.

Source files
------------

// File: rtl/instruction_loader.sv
// Assembles big-endian instruction words from a byte stream and writes them to instruction memory.
// Optional trailing XOR checksum after HALT is enabled by defining LOADER_CHECKSUM_EN.
module instruction_loader #(
  parameter int INST_SZ = 32,
  parameter int BYTE_SZ = 8,
  parameter int ADDR_SZ = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [BYTE_SZ-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_clear,
  output logic               o_ready,
  output logic               o_write,
  output logic [INST_SZ-1:0] o_instruction,
  output logic [ADDR_SZ-1:0] o_addr,
  output logic [ADDR_SZ:0]   o_word_count,
  output logic               o_done,
  output logic               o_error
);

  localparam int NBYTES = INST_SZ / BYTE_SZ;
  localparam int CNT_W  = $clog2(NBYTES + 1);
  localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [ADDR_SZ-1:0] ADDR_MAX  = '1;

  typedef enum logic [2:0] {
    S_RECV,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [INST_SZ-1:0] r_buf;
  logic [INST_SZ-1:0] r_instr;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_SZ-1:0] r_addr;
  logic [ADDR_SZ:0]   r_word_count;
  logic [INST_SZ-1:0] w_shift;
  logic               w_accept;
  logic               w_last;
  logic               w_halt;

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_SZ-1:0] r_csum;
  assign o_ready = (r_state == S_RECV) || (r_state == S_CHECK);
`else
  assign o_ready = (r_state == S_RECV);
`endif

  // i_clear wins over a byte arriving in the same cycle
  assign w_accept = o_ready && i_rx_valid && !i_clear;
  assign w_last   = (r_state == S_RECV) && w_accept && (r_cnt == LAST_BYTE);
  assign w_shift  = (r_buf << BYTE_SZ) | INST_SZ'(i_rx_data);
  assign w_halt   = &r_instr;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_RECV;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (i_clear) begin
      w_next = S_RECV;
    end else begin
      case (r_state)
        S_RECV: begin
          if (w_last) w_next = S_WRITE;
        end
        S_WRITE: begin
          if (w_halt) begin
`ifdef LOADER_CHECKSUM_EN
            w_next = S_CHECK;
`else
            w_next = S_DONE;
`endif
          end else if (r_addr == ADDR_MAX) begin
            w_next = S_ERROR;
          end else begin
            w_next = S_RECV;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (w_accept) w_next = (i_rx_data == r_csum) ? S_DONE : S_ERROR;
        end
`endif
        S_DONE:  w_next = S_DONE;
        S_ERROR: w_next = S_ERROR;
        default: w_next = S_RECV;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_buf        <= '0;
      r_instr      <= '0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else if (i_clear) begin
      r_buf        <= '0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_word_count <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      if ((r_state == S_RECV) && w_accept) begin
`ifdef LOADER_CHECKSUM_EN
        r_csum <= r_csum ^ i_rx_data;
`endif
        if (w_last) begin
          r_instr <= w_shift;
          r_buf   <= '0;
          r_cnt   <= '0;
        end else begin
          r_buf   <= w_shift;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
      end
      // address saturates at the top so an overflow reports the failing slot
      if (r_state == S_WRITE) begin
        r_word_count <= r_word_count + (ADDR_SZ + 1)'(1);
        if (r_addr != ADDR_MAX) r_addr <= r_addr + ADDR_SZ'(1);
      end
    end
  end

  assign o_write       = (r_state == S_WRITE);
  assign o_instruction = r_instr;
  assign o_addr        = r_addr;
  assign o_word_count  = r_word_count;
  assign o_done        = (r_state == S_DONE);
  assign o_error       = (r_state == S_ERROR);

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed vectors plus random byte traffic against a cycle-level model.
module tb_instruction_loader;
  localparam int IW   = 32;
  localparam int BW   = 8;
  localparam int AW   = 2;
  localparam int AMAX = 3;
  localparam int P_RECV = 0, P_WR = 1, P_CHK = 2, P_DONE = 3, P_ERR = 4;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_reset = 1'b0;
  logic [BW-1:0] i_rx_data = '0;
  logic          i_rx_valid = 1'b0;
  logic          i_clear = 1'b0;
  logic          o_ready, o_write, o_done, o_error;
  logic [IW-1:0] o_instruction;
  logic [AW-1:0] o_addr;
  logic [AW:0]   o_word_count;

  always #5 i_clk = ~i_clk;

  instruction_loader #(.INST_SZ(IW), .BYTE_SZ(BW), .ADDR_SZ(AW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_clear(i_clear), .o_ready(o_ready), .o_write(o_write), .o_instruction(o_instruction),
    .o_addr(o_addr), .o_word_count(o_word_count), .o_done(o_done), .o_error(o_error)
  );

  int checks = 0;
  int errors = 0;

  int            m_phase;
  logic [7:0]    m_q[$];
  int            m_addr;
  int            m_count;
  logic [31:0]   m_instr;
  logic [7:0]    m_xor;
  logic [31:0]   log_data[$];
  int            log_addr[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_RECV; m_q.delete(); m_addr = 0; m_count = 0; m_instr = '0; m_xor = '0;
  endfunction

  function automatic void model_clock(input logic v, input logic [7:0] d, input logic c);
    int old_addr;
    if (c) begin
      m_phase = P_RECV; m_q.delete(); m_addr = 0; m_count = 0; m_xor = '0;
      return;
    end
    case (m_phase)
      P_RECV: if (v) begin
        m_q.push_back(d);
        m_xor ^= d;
        if (m_q.size() == 4) begin
          m_instr = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_q.delete();
          m_phase = P_WR;
        end
      end
      P_WR: begin
        old_addr = m_addr;
        m_count++;
        if (m_addr < AMAX) m_addr++;
        if (m_instr == 32'hFFFF_FFFF) m_phase = CSUM ? P_CHK : P_DONE;
        else if (old_addr == AMAX)    m_phase = P_ERR;
        else                          m_phase = P_RECV;
      end
      P_CHK: if (v) m_phase = (d == m_xor) ? P_DONE : P_ERR;
      default: ;
    endcase
  endfunction

  task automatic check_outputs();
    chk("ready", o_ready, (m_phase == P_RECV) || (m_phase == P_CHK));
    chk("write", o_write, m_phase == P_WR);
    chk("instr", o_instruction, m_instr);
    chk("addr", o_addr, m_addr);
    chk("count", o_word_count, m_count);
    chk("done", o_done, m_phase == P_DONE);
    chk("error", o_error, m_phase == P_ERR);
    if (o_write) begin
      log_data.push_back(o_instruction);
      log_addr.push_back(int'(o_addr));
    end
  endtask

  // called at a negedge; returns at the next negedge
  task automatic step(input logic v, input logic [7:0] d, input logic c);
    check_outputs();
    i_rx_valid = v; i_rx_data = d; i_clear = c;
    @(posedge i_clk);
    model_clock(v, d, c);
    @(negedge i_clk);
    i_rx_valid = 1'b0; i_clear = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    while (!(m_phase == P_RECV || m_phase == P_CHK) && n < 8) begin
      step(1'b0, 8'h00, 1'b0);
      n++;
    end
    if (n == 8) begin
      checks++; errors++;
      $display("FAIL send_wait: loader not ready after %0d cycles", n);
    end
    step(1'b1, d, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    #2;
    model_reset();
    check_outputs();
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    model_reset();
    @(negedge i_clk);
    do_reset();

    // two-word load ending in HALT
    base = log_data.size();
    send_word(32'h2008_0005);
    send_word(32'hFFFF_FFFF);
    if (CSUM) send(8'h20 ^ 8'h08 ^ 8'h00 ^ 8'h05);
    idle(2);
    chk("v1_nwrites", log_data.size() - base, 2);
    chk("v1_w0", log_data[base], 32'h2008_0005);
    chk("v1_a0", log_addr[base], 0);
    chk("v1_w1", log_data[base+1], 32'hFFFF_FFFF);
    chk("v1_a1", log_addr[base+1], 1);
    chk("v1_count", o_word_count, 2);
    chk("v1_done", o_done, 1'b1);

    // back-to-back bytes: the one arriving during WRITE is lost; DONE ignores bytes
    step(1'b0, 8'h00, 1'b1);
    base = log_data.size();
    step(1'b1, 8'h11, 1'b0); step(1'b1, 8'h22, 1'b0); step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0); step(1'b1, 8'h55, 1'b0); step(1'b1, 8'h66, 1'b0);
    step(1'b1, 8'h77, 1'b0); step(1'b1, 8'h88, 1'b0); step(1'b1, 8'h99, 1'b0);
    send_word(32'hFFFF_FFFF);
    if (CSUM) send(m_xor);
    idle(1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h5A, 1'b0);
    chk("v2_nwrites", log_data.size() - base, 3);
    chk("v2_w0", log_data[base], 32'h1122_3344);
    chk("v2_w1", log_data[base+1], 32'h6677_8899);
    chk("v2_count", o_word_count, 3);
    chk("v2_done", o_done, 1'b1);

    // clear in DONE beats a simultaneous byte
    step(1'b1, 8'hEE, 1'b1);
    chk("v3_count", o_word_count, 0);
    chk("v3_ready", o_ready, 1'b1);
    base = log_data.size();
    send_word(32'h0102_0304);
    idle(1);
    chk("v3_word", log_data[base], 32'h0102_0304);
    chk("v3_addr", log_addr[base], 0);

    // overflow at the top address
    step(1'b0, 8'h00, 1'b1);
    base = log_data.size();
    for (int i = 0; i < 4; i++) send_word(32'h1000_0000 + i);
    idle(2);
    step(1'b1, 8'h01, 1'b0);
    chk("v4_nwrites", log_data.size() - base, 4);
    chk("v4_lastaddr", log_addr[base+3], 3);
    chk("v4_error", o_error, 1'b1);
    chk("v4_addr", o_addr, 3);
    chk("v4_count", o_word_count, 4);

    // reset mid-word discards partial bytes
    step(1'b0, 8'h00, 1'b1);
    send(8'h12); send(8'h34);
    do_reset();
    base = log_data.size();
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    idle(2);
    chk("v5_nwrites", log_data.size() - base, 1);
    chk("v5_word", log_data[base], 32'hAABB_CCDD);
    chk("v5_addr", log_addr[base], 0);

`ifdef LOADER_CHECKSUM_EN
    step(1'b0, 8'h00, 1'b1);
    send_word(32'h0102_0304); send_word(32'hFFFF_FFFF); send(8'h04);
    idle(1);
    chk("v6_good_done", o_done, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    send_word(32'h0102_0304); send_word(32'hFFFF_FFFF); send(8'h05);
    idle(1);
    chk("v6_bad_error", o_error, 1'b1);
`endif

    // random traffic, bytes biased toward FF so HALT words occur
    for (int s = 0; s < 20; s++) begin
      step(1'b0, 8'h00, 1'b1);
      for (int c = 0; c < 40; c++) begin
        logic [7:0] d;
        d = ($urandom_range(0, 9) < 6) ? 8'hFF : 8'($urandom);
        if (m_phase == P_CHK && $urandom_range(0, 1) == 1) d = m_xor;
        step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 49) == 0));
      end
    end
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
